// File: rtl/sprite_reg_bank.sv
// sprite_reg_bank: double-buffered sprite register bank for a tile/sprite renderer.
// The CPU sees a shadow copy of every sprite byte. The renderer reads an active copy
// that is refreshed in one edge at vertical blank, unless the CPU holds the frame lock.
// The block also holds a saturating score accumulator, a displayed score, a frame
// counter and a window of read-only external status words.
module sprite_reg_bank #(
  parameter int NUM_SPRITES = 5,
  parameter int FIELDS      = 6,
  parameter int NUM_EXT     = 4,
  parameter int FRAME_W     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             reg_addr,
  input  logic [15:0]            in,
  input  logic                   we,
  output logic [15:0]            out,
  input  logic                   vblank,
  input  logic [3:0]             disp_sprite,
  input  logic [2:0]             disp_field,
  output logic [7:0]             disp_data,
  output logic                   commit_done,
  input  logic [16*NUM_EXT-1:0]  ext_in
);

  localparam logic [6:0] ADDR_LOCK       = 7'h60;
  localparam logic [6:0] ADDR_SCORE      = 7'h61;
  localparam logic [6:0] ADDR_SCORE_ADD  = 7'h62;
  localparam logic [6:0] ADDR_SCORE_DISP = 7'h63;
  localparam logic [6:0] ADDR_STATUS     = 7'h64;
  localparam logic [6:0] ADDR_FRAME      = 7'h65;

  // Score accumulation saturates at full scale instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Only valid (sprite, field) slots are stored; out-of-range slots have no storage.
  logic [7:0]         shadow_q [NUM_SPRITES][FIELDS];
  logic [7:0]         shadow_d [NUM_SPRITES][FIELDS];
  logic [7:0]         active_q [NUM_SPRITES][FIELDS];
  logic [7:0]         active_d [NUM_SPRITES][FIELDS];

  logic               lock_q, lock_d;
  logic               dirty_q, dirty_d;
  logic [15:0]        score_q, score_d;
  logic [15:0]        score_disp_q, score_disp_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         disp_data_q, disp_data_d;
  logic               commit_done_q, commit_done_d;

  logic               spr_hit;
  logic               commit_go;

  // A commit needs pending shadow changes and uses the lock value held before this edge.
  assign commit_go = vblank && !lock_q && dirty_q;

  // Does the current address hit a valid sprite byte?
  always_comb begin
    spr_hit = 1'b0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      for (int f = 0; f < FIELDS; f++) begin
        if (reg_addr == 7'(s * 8 + f)) spr_hit = 1'b1;
      end
    end
  end

  // Shadow bank takes CPU writes; active bank snapshots the pre-write shadow on commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit_go) active_d = shadow_q;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      for (int f = 0; f < FIELDS; f++) begin
        if (we && (reg_addr == 7'(s * 8 + f))) shadow_d[s][f] = in[7:0];
      end
    end
  end

  // Control and game-state registers: lock, dirty, score, displayed score, frame.
  always_comb begin
    lock_d        = lock_q;
    dirty_d       = dirty_q;
    score_d       = score_q;
    score_disp_d  = score_disp_q;
    frame_d       = frame_q;
    commit_done_d = commit_go;

    // A write landing on the commit edge re-marks the shadow as dirty.
    if (commit_go) dirty_d = 1'b0;
    if (we && spr_hit) dirty_d = 1'b1;

    if (we) begin
      case (reg_addr)
        ADDR_LOCK:       lock_d       = in[0];
        ADDR_SCORE:      score_d      = in;
        ADDR_SCORE_ADD:  score_d      = sat_add16(score_q, in);
        ADDR_SCORE_DISP: score_disp_d = in;
        default: ;
      endcase
    end

    if (vblank) frame_d = frame_q + FRAME_W'(1);
  end

  // Renderer byte select; invalid selects fall through to zero.
  always_comb begin
    disp_data_d = 8'h00;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      for (int f = 0; f < FIELDS; f++) begin
        if ((disp_sprite == 4'(s)) && (disp_field == 3'(f))) disp_data_d = active_q[s][f];
      end
    end
  end

  // CPU read mux, combinational from reg_addr.
  always_comb begin
    out = 16'h0000;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      for (int f = 0; f < FIELDS; f++) begin
        if (reg_addr == 7'(s * 8 + f)) out = {8'h00, shadow_q[s][f]};
      end
    end
    for (int k = 0; k < NUM_EXT; k++) begin
      if (reg_addr == 7'(32'h70 + k)) out = ext_in[16*k +: 16];
    end
    case (reg_addr)
      ADDR_LOCK:       out = {15'b0, lock_q};
      ADDR_SCORE:      out = score_q;
      ADDR_SCORE_DISP: out = score_disp_q;
      ADDR_STATUS:     out = {14'b0, lock_q, dirty_q};
      ADDR_FRAME:      out = 16'(frame_q);
      default: ;
    endcase
  end

  // Sprite storage registers; asynchronous reset clears both banks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        for (int f = 0; f < FIELDS; f++) begin
          shadow_q[s][f] <= 8'h00;
          active_q[s][f] <= 8'h00;
        end
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Control, score, frame and renderer-facing output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q        <= 1'b0;
      dirty_q       <= 1'b0;
      score_q       <= 16'h0000;
      score_disp_q  <= 16'h0000;
      frame_q       <= '0;
      disp_data_q   <= 8'h00;
      commit_done_q <= 1'b0;
    end else begin
      lock_q        <= lock_d;
      dirty_q       <= dirty_d;
      score_q       <= score_d;
      score_disp_q  <= score_disp_d;
      frame_q       <= frame_d;
      disp_data_q   <= disp_data_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign disp_data   = disp_data_q;
  assign commit_done = commit_done_q;

endmodule

// File: doc/sprite_reg_bank.md
# sprite_reg_bank

Parametrised, double-buffered sprite and game-state register bank. It sits between the game CPU and the sprite/tile renderer. The CPU reads and writes a shadow copy of every sprite register. The renderer reads a separate active copy, which is refreshed atomically at vertical blank unless the CPU holds the frame lock. The block also owns a saturating score accumulator, a displayed-score register, a frame counter, and a window of read-only external status inputs.

## Interface
- NUM_SPRITES, 5, number of sprite channels (1..12); channel 0 is PacMan, then ghosts.
- FIELDS, 6, byte fields used per sprite (1..8); sprite stride in the address map is always 8.
- NUM_EXT, 4, number of 16-bit external read-only inputs (1..16).
- FRAME_W, 6, frame counter width (1..16).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- reg_addr  in  7  CPU register address.
- in  in  16  CPU write data.
- we  in  1  CPU write strobe, one write per asserted cycle.
- out  out  16  CPU read data, combinational from reg_addr.
- vblank  in  1  one-cycle pulse at the start of vertical blank.
- disp_sprite  in  4  renderer sprite select.
- disp_field  in  3  renderer field select.
- disp_data  out  8  active-bank byte for disp_sprite/disp_field, registered.
- commit_done  out  1  one-cycle pulse after a shadow-to-active commit.
- ext_in  in  16*NUM_EXT  external status words; word k is bits [16k+15:16k].

## Operation
- **Address map (reg_addr):**
  - 0x00..0x5F: sprite byte s*8+f.
    - Valid when s<NUM_SPRITES and f<FIELDS.
    - Valid entries read/write shadow bits [7:0]; out[15:8]=0.
    - Invalid entries read 0 and ignore writes.
  - 0x60 LOCK: bit0 only. Writes store in[0]; reads return {15'b0, lock}.
  - 0x61 SCORE: read/write, 16 bits.
  - 0x62 SCORE_ADD: write-only. score <= min(score + in, 16'hFFFF), computed in 17 bits. Reads return 0.
  - 0x63 SCORE_DISP: read/write, 16 bits, single-buffered.
  - 0x64 STATUS: read-only {14'b0, lock, dirty}.
  - 0x65 FRAME: read-only, zero-extended frame counter. Writes are ignored.
  - 0x70+k: ext_in word k for k<NUM_EXT. Reads 0 otherwise; writes ignored.
  - All other addresses read 0 and ignore writes.
- **dirty flag:**
  - Set by any accepted write to a valid sprite byte.
  - Cleared by a commit.
- **Commit:**
  - On a cycle with vblank=1, lock=0 and dirty=1, every valid active byte is loaded from shadow in that single edge.
  - If lock=1 or dirty=0, nothing is copied.
  - Commits are not deferred: a blocked vblank is simply skipped. The next vblank with the lock clear commits.
- **Frame counter:** increments on every vblank pulse regardless of lock, and wraps modulo 2^FRAME_W.
- **disp_data:** active[disp_sprite][disp_field], or 0 for an invalid select.

## Timing
- Reset (reset=0, asynchronous) clears all of the following:
  - shadow bytes, active bytes;
  - lock, dirty;
  - score, score_disp, frame counter;
  - disp_data and commit_done.
  - out then reflects the cleared state, plus ext_in at 0x70+.
- Writes take effect at the rising edge where we=1. Combinational out shows the new value in the next cycle.
- disp_data has 1-cycle latency from disp_sprite/disp_field. It reflects a commit at edge N starting from the edge N+1 sample.
- commit_done is high for exactly the cycle following the commit edge.
- **Write and commit on the same edge:**
  - The active bank receives the pre-write shadow value.
  - The shadow takes the new value.
  - dirty remains 1.
- **LOCK write and vblank on the same edge:** the commit decision uses the old lock value.
- **SCORE_ADD:** the sum saturates and never wraps, e.g. 0xFFF0 + 0x0020 gives 0xFFFF.
- **Reset mid-commit:** the asynchronous clear wins. No partial copy is observable after reset releases.

## Test plan
- **Reset and map:** reset low, then release.
  - Reads of 0x00, 0x61 and 0x65 return 0.
  - A read of 0x70 returns ext_in[15:0]=0x1234.
  - A read of 0x7F returns 0.
- **Commit:** write 0x42 to 0x08 (sprite 1 field 0).
  - out=0x0042 and STATUS=0x0001.
  - disp_data for (1,0) stays 0x00 until vblank.
  - After the vblank edge: disp_data=0x42 on the next sample, commit_done pulses once, STATUS=0x0000.
- **Lock:** write LOCK=1, write 0x07 to 0x00, pulse vblank.
  - Active byte stays 0; commit_done stays 0; FRAME=1.
  - Write LOCK=0 and pulse vblank: active byte becomes 0x07.
- **Simultaneous:** assert we to 0x00 with 0x55 in the same cycle as vblank, with a prior shadow value of 0x11.
  - Active byte = 0x11, shadow = 0x55, dirty = 1.
- **Score:** write SCORE=0xFFF0, then SCORE_ADD=0x0020 → SCORE reads 0xFFFF. Write SCORE=10, then SCORE_ADD=5 → SCORE reads 15.
- **Invalid slots and wrap:**
  - With FIELDS=6, a write to 0x06 reads 0 and dirty stays 0.
  - After 64 vblanks with FRAME_W=6, FRAME reads 0.
